// File: rtl/m_tick_counter_pkg.sv
// Shared constants and helpers for periodic tick generators.
// Default terminal counts assume a 100 MHz system clock.
package m_tick_counter_pkg;

    localparam int unsigned MS_MAXCOUNT = 99_999;
    localparam int unsigned US_MAXCOUNT = 99;

    function automatic int unsigned cw_for(input int unsigned max);
        return $clog2(64'(max) + 64'd1);
    endfunction

endpackage

// File: rtl/m_tick_term_detect.sv
// Registers the "counter is one short of terminal" compare into the tic flop,
// so tic comes straight from a register and is high while cnt == MAXCOUNT.
module m_tick_term_detect
    import m_tick_counter_pkg::*;
#(
    parameter int unsigned MAXCOUNT = MS_MAXCOUNT,
    parameter int unsigned CW       = cw_for(MAXCOUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cnt,
    output logic          tic
);

    localparam logic [CW-1:0] PRE_TERM = CW'(MAXCOUNT - 1);

    logic tic_d;
    logic tic_q;

    always_comb begin
        tic_d = 1'b0;
        if (cnt == PRE_TERM) tic_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) tic_q <= 1'b0;
        else     tic_q <= tic_d;
    end

    assign tic = tic_q;

endmodule

// File: rtl/m_tick_counter.sv
// Free-running clock divider: one-cycle tic strobe every MAXCOUNT+1 cycles,
// intended as a clock-enable for downstream timers.
module m_tick_counter
    import m_tick_counter_pkg::*;
#(
    parameter int unsigned MAXCOUNT = MS_MAXCOUNT
) (
    input  logic clk,
    input  logic rst,
    output logic tic
);

    localparam int unsigned     CW   = cw_for(MAXCOUNT);
    localparam logic [CW-1:0]   TERM = CW'(MAXCOUNT);

    if (MAXCOUNT < 1) begin : g_bad_maxcount
        $error("m_tick_counter: MAXCOUNT must be at least 1");
    end
    if (MAXCOUNT > 32'h7fff_ffff) begin : g_big_maxcount
        $error("m_tick_counter: MAXCOUNT must not exceed 2^31-1");
    end

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // >= rather than == so an upset into the unused code space still wraps.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q >= TERM) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    m_tick_term_detect #(
        .MAXCOUNT (MAXCOUNT),
        .CW       (CW)
    ) u_term (
        .clk (clk),
        .rst (rst),
        .cnt (cnt_q),
        .tic (tic)
    );

endmodule

// File: tb/tb_m_tick_counter.sv
// Scoreboard bench for m_tick_counter at MAXCOUNT = 4, 1 and 99.
// Expected tic/cnt come from counting non-reset edges since the last reset.
module tb_m_tick_counter;
    import m_tick_counter_pkg::*;

    localparam int NDUT = 3;
    localparam int unsigned M0 = 4;
    localparam int unsigned M1 = 1;
    localparam int unsigned M2 = US_MAXCOUNT;

    typedef struct {
        bit          tic [NDUT];
        int unsigned cnt [NDUT];
    } exp_t;

    logic clk = 1'b0;
    logic [NDUT-1:0] rst = '1;
    logic [NDUT-1:0] tic;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    int unsigned k [NDUT];
    int unsigned mc [NDUT];

    always #5 clk = ~clk;

    m_tick_counter #(.MAXCOUNT(M0)) dut0 (.clk(clk), .rst(rst[0]), .tic(tic[0]));
    m_tick_counter #(.MAXCOUNT(M1)) dut1 (.clk(clk), .rst(rst[1]), .tic(tic[1]));
    m_tick_counter #(.MAXCOUNT(M2)) dut2 (.clk(clk), .rst(rst[2]), .tic(tic[2]));

    // Drive one cycle of reset values and record what the next edge must produce.
    task automatic step(input logic [NDUT-1:0] r);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r;
        for (int i = 0; i < NDUT; i++) begin
            if (r[i]) k[i] = 0;
            else      k[i] = k[i] + 1;
            e.cnt[i] = k[i] % (mc[i] + 1);
            e.tic[i] = (e.cnt[i] == mc[i]);
        end
        exp_q.push_back(e);
    endtask

    function automatic int unsigned cur_cnt(input int i);
        return k[i] % (mc[i] + 1);
    endfunction

    // Monitor: pops one expectation per edge and compares 1 time unit later.
    initial begin
        exp_t e;
        int unsigned act [NDUT];
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                act[0] = 32'(dut0.cnt_q);
                act[1] = 32'(dut1.cnt_q);
                act[2] = 32'(dut2.cnt_q);
                for (int i = 0; i < NDUT; i++) begin
                    checks++;
                    if (tic[i] !== e.tic[i]) begin
                        errors++;
                        $display("FAIL tic dut%0d t=%0t got %b want %b", i, $time, tic[i], e.tic[i]);
                    end
                    checks++;
                    if (act[i] != e.cnt[i]) begin
                        errors++;
                        $display("FAIL cnt dut%0d t=%0t got %0d want %0d", i, $time, act[i], e.cnt[i]);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        mc[0] = M0; mc[1] = M1; mc[2] = M2;
        for (int i = 0; i < NDUT; i++) k[i] = 0;

        // Long reset hold.
        repeat (50) step('1);
        // Release: first tic after MAXCOUNT edges, then several periods.
        repeat (230) step('0);

        // Mid-count reset on dut0 when cnt == 2.
        n = 0;
        while (cur_cnt(0) != 2 && n < 20) begin step('0); n++; end
        step(3'b001);
        repeat (12) step('0);

        // Reset asserted in the tic-high cycle of dut0 and dut1.
        n = 0;
        while (!(cur_cnt(0) == M0 && cur_cnt(1) == M1) && n < 40) begin step('0); n++; end
        step(3'b011);
        repeat (12) step('0);

        // Reset coinciding with cnt == MAXCOUNT-1 on dut0 and dut2.
        n = 0;
        while (cur_cnt(0) != M0 - 1 && n < 20) begin step('0); n++; end
        step(3'b001);
        n = 0;
        while (cur_cnt(2) != M2 - 1 && n < 200) begin step('0); n++; end
        step(3'b100);
        repeat (12) step('0);

        // Random sparse resets per instance.
        repeat (4000) begin
            logic [NDUT-1:0] r;
            for (int i = 0; i < NDUT; i++) r[i] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0) r[2] = 1'b0;
            step(r);
        end
        repeat (300) step('0);

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
